vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing source at the head of the video pipeline; sits directly upstream of the star-field and object draw stages.
- Generates the pixel-clock enable, pixel coordinates, active-video flag, sync pulses and a frame-start strobe from the system clock.
- Every draw stage consumes its coordinates. The star layer's per-frame reseed keys on pxl_x==0 && pxl_y==0, so each frame must present (0,0) exactly once.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pxl_en  out  1  one-clk pulse each pixel period; coordinates are valid and new on this cycle
- pxl_x  out  $clog2(H_TOTAL)  horizontal count 0..H_TOTAL-1 (H_TOTAL = sum of H_*)
- pxl_y  out  $clog2(V_TOTAL)  vertical count 0..V_TOTAL-1
- active  out  1  high when pxl_x<H_ACTIVE and pxl_y<V_ACTIVE
- hsync  out  1  horizontal sync at SYNC_POL level when asserted
- vsync  out  1  vertical sync at SYNC_POL level when asserted
- frame_start  out  1  one-clk pulse coincident with pxl_en when (pxl_x,pxl_y) becomes (0,0)

Behaviour:
- Reset: asynchronous, active-high, valid in any state including mid-frame.
  - Internal div count, hcnt and vcnt go to 0.
  - pxl_x=0, pxl_y=0, pxl_en=0, active=0, frame_start=0.
  - hsync and vsync at the deasserted level (~SYNC_POL).
- Divider:
  - dcnt counts 0..CLK_DIV-1 and wraps.
  - tick = (dcnt==CLK_DIV-1).
  - CLK_DIV=1 gives tick every cycle.
- Counters, advancing on tick only:
  - hcnt increments and wraps H_TOTAL-1 -> 0.
  - On the hcnt wrap, vcnt increments and wraps V_TOTAL-1 -> 0.
  - Simultaneous h and v wrap: both go to 0 on the same tick.
- Outputs: all registered, updated on the cycle after tick, together with pxl_en=1.
  - pxl_x/pxl_y hold steady for CLK_DIV clks between updates.
  - First pxl_en after reset release arrives CLK_DIV clks after release, presenting (1,0). The post-reset (0,0) is not strobed.
  - frame_start=0 for that first update; the first frame_start arrives at the first vcnt wrap.
- Sync decode, from the post-update counters:
  - hsync asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
  - active follows the same registered counters, so it is always aligned with pxl_x/pxl_y.
- Widths:
  - Compare and wrap arithmetic use counter-width constants.
  - No overflow is possible, because the counter width is $clog2 of the total.
- Totals: H_TOTAL=800 and V_TOTAL=525 at the defaults.
- Static parameter checks (elaboration error): CLK_DIV<1, or any porch/sync/active value of 0.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN
- When defined, adds outputs tp_red[3:0], tp_green[3:0], tp_blue[3:0], registered and aligned with pxl_x/active.
  - Active region shows 8 vertical colour bars, each H_ACTIVE/8 wide.
  - Bar index b = pxl_x / (H_ACTIVE/8); red = {4{b[2]}}, green = {4{b[1]}}, blue = {4{b[0]}}.
  - All zero when active=0 or during reset.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset held 5 clks then released, defaults -> all outputs at reset values throughout reset; first pxl_en exactly 2 clks after release with pxl_x=1, pxl_y=0, active=1, frame_start=0.
- Run one full frame, defaults -> pxl_en count between successive frame_start pulses = 420000 (800*525); frame_start period = 840000 clks.
- Horizontal sync, defaults -> hsync low (SYNC_POL=0) for exactly 96 pixel updates starting at pxl_x=656 and ending after pxl_x=751; active falls on the update to pxl_x=640.
- Vertical boundary -> on the update after (799,524), pxl_x=0, pxl_y=0, frame_start=1 for one clk; vsync low for pxl_y 490..491 only.
- Assert reset at (pxl_x=300, pxl_y=200) -> outputs return to reset values within the same clk (asynchronous); after release, counting restarts from (1,0).
- CLK_DIV=1, SYNC_POL=1 -> pxl_en high every clk after release; hsync high only for pxl_x 656..751. With VGA_TIMING_TEST_PATTERN_EN defined: pxl_x=0 gives rgb=0,0,0; pxl_x=560 gives rgb=F,F,F; pxl_x=700 gives 0,0,0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Raster timing bundle produced by vga_timing_gen and consumed by the draw
// stages (star field, object layers).
//
// Parameters:
//   XW : width of pxl_x, must equal $clog2(H_TOTAL) of the generator
//   YW : width of pxl_y, must equal $clog2(V_TOTAL) of the generator
//
// Signals:
//   pxl_en       one-clk pulse per pixel period, coordinates new on this cycle
//   pxl_x/pxl_y  raster coordinates (blanking included)
//   active       visible-area flag aligned with pxl_x/pxl_y
//   hsync/vsync  sync pulses at the generator's SYNC_POL level when asserted
//   frame_start  one-clk pulse with pxl_en when the raster returns to (0,0)
//   tp_red/tp_green/tp_blue  colour-bar test pattern, only when the macro
//                VGA_TIMING_TEST_PATTERN_EN is defined
//
// Modports: master = generator side (drives), slave = draw-stage side (reads).
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          pxl_en;
    logic [XW-1:0] pxl_x;
    logic [YW-1:0] pxl_y;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          frame_start;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [3:0]    tp_red;
    logic [3:0]    tp_green;
    logic [3:0]    tp_blue;

    modport master (output pxl_en, pxl_x, pxl_y, active, hsync, vsync,
                    frame_start, tp_red, tp_green, tp_blue);
    modport slave  (input  pxl_en, pxl_x, pxl_y, active, hsync, vsync,
                    frame_start, tp_red, tp_green, tp_blue);
`else
    modport master (output pxl_en, pxl_x, pxl_y, active, hsync, vsync,
                    frame_start);
    modport slave  (input  pxl_en, pxl_x, pxl_y, active, hsync, vsync,
                    frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing source at the head of the video pipeline. Divides the system
// clock down to a pixel enable, runs the horizontal/vertical raster counters
// and decodes active video, sync pulses and a frame-start strobe. All outputs
// are registered and change together on the cycle after the internal tick.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   vid    master modport of vga_timing_gen_if (pxl_en, pxl_x, pxl_y, active,
//          hsync, vsync, frame_start[, tp_red, tp_green, tp_blue])
//
// Optional feature macro: VGA_TIMING_TEST_PATTERN_EN
//   When defined, drives an 8-bar colour test pattern on tp_red/green/blue.
//
// The interface instance must be built with XW=$clog2(H_TOTAL) and
// YW=$clog2(V_TOTAL) for the parameters chosen here.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Counter-width constants so every compare is width-matched.
    localparam logic [DW-1:0] D_LAST     = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC);

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
        $error("vga_timing_gen: CLK_DIV and all active/porch/sync values must be >= 1");
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam logic [XW-1:0] BAR_W = XW'(H_ACTIVE / 8);

    if (H_ACTIVE < 8) begin : g_bad_tp
        $error("vga_timing_gen: test pattern needs H_ACTIVE >= 8");
    end
`endif

    // Map a decoded "sync asserted" condition onto the configured pin level.
    function automatic logic sync_level(input logic asserted);
        return asserted ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic [DW-1:0] dcnt_r;
    logic [XW-1:0] hcnt_r;
    logic [YW-1:0] vcnt_r;
    logic          tick_s;
    logic [XW-1:0] hnext_s;
    logic [YW-1:0] vnext_s;
    logic          act_s;
    logic          hs_on_s;
    logic          vs_on_s;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [2:0]    bar_s;
`endif

    assign tick_s    = (dcnt_r == D_LAST);
    // The horizontal counter register is itself the pxl_x output.
    assign vid.pxl_x = hcnt_r;
    assign vid.pxl_y = vcnt_r;

    // Next raster position and its decode; outputs are computed from the
    // post-update counters so they line up with the new coordinates.
    always_comb begin
        hnext_s = hcnt_r;
        vnext_s = vcnt_r;
        if (hcnt_r == H_LAST) begin
            hnext_s = '0;
            if (vcnt_r == V_LAST) begin
                vnext_s = '0;
            end else begin
                vnext_s = vcnt_r + YW'(1);
            end
        end else begin
            hnext_s = hcnt_r + XW'(1);
        end
        act_s   = (hnext_s < H_ACT_END) && (vnext_s < V_ACT_END);
        hs_on_s = (hnext_s >= H_SYNC_BEG) && (hnext_s < H_SYNC_END);
        vs_on_s = (vnext_s >= V_SYNC_BEG) && (vnext_s < V_SYNC_END);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        bar_s   = 3'(hnext_s / BAR_W);
`endif
    end

    // Pixel-period divider: tick on the last system clock of each pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt_r <= '0;
        end else if (tick_s) begin
            dcnt_r <= '0;
        end else begin
            dcnt_r <= dcnt_r + DW'(1);
        end
    end

    // Raster counters and registered timing outputs, advanced once per tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_r          <= '0;
            vcnt_r          <= '0;
            vid.pxl_en      <= 1'b0;
            vid.active      <= 1'b0;
            vid.hsync       <= ~SYNC_POL;
            vid.vsync       <= ~SYNC_POL;
            vid.frame_start <= 1'b0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
            vid.tp_red      <= 4'h0;
            vid.tp_green    <= 4'h0;
            vid.tp_blue     <= 4'h0;
`endif
        end else if (tick_s) begin
            hcnt_r          <= hnext_s;
            vcnt_r          <= vnext_s;
            vid.pxl_en      <= 1'b1;
            vid.active      <= act_s;
            vid.hsync       <= sync_level(hs_on_s);
            vid.vsync       <= sync_level(vs_on_s);
            // The post-reset (0,0) never passes through here, so the first
            // strobe is the first true wrap of both counters.
            vid.frame_start <= (hnext_s == '0) && (vnext_s == '0);
`ifdef VGA_TIMING_TEST_PATTERN_EN
            vid.tp_red      <= act_s ? {4{bar_s[2]}} : 4'h0;
            vid.tp_green    <= act_s ? {4{bar_s[1]}} : 4'h0;
            vid.tp_blue     <= act_s ? {4{bar_s[0]}} : 4'h0;
`endif
        end else begin
            vid.pxl_en      <= 1'b0;
            vid.frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;
    typedef struct {
        int         x;
        int         y;
        bit         act;
        bit         hs;
        bit         vs;
        bit         fs;
        logic [11:0] rgb;
    } exp_t;

    logic   clk   = 1'b0;
    logic   rst_a = 1'b1;
    logic   rst_b = 1'b1;
    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc   = 0;
    exp_t   qa[$];
    exp_t   qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: default timing. DUT B: CLK_DIV=1, active-high sync, short frame.
    vga_timing_gen_if #(.XW(10), .YW(10)) va();
    vga_timing_gen_if #(.XW(10), .YW(3))  vb();

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .SYNC_POL(1'b0)
    ) u_a (.clk(clk), .reset(rst_a), .vid(va));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) u_b (.clk(clk), .reset(rst_b), .vid(vb));

    task automatic chk(input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Expected outputs for linear pixel index p counted from the reset frame origin.
    function automatic exp_t model(input int p, input int ha, input int hfp, input int hsw,
                                   input int hbp, input int vact, input int vfp, input int vsw,
                                   input int vbp, input bit pol);
        exp_t e;
        int   ht, vt, b;
        logic [2:0] bb;
        ht    = ha + hfp + hsw + hbp;
        vt    = vact + vfp + vsw + vbp;
        e.x   = p % ht;
        e.y   = (p / ht) % vt;
        e.fs  = (e.x == 0) && (e.y == 0);
        e.act = (e.x < ha) && (e.y < vact);
        e.hs  = (e.x >= ha + hfp && e.x < ha + hfp + hsw) ? pol : !pol;
        e.vs  = (e.y >= vact + vfp && e.y < vact + vfp + vsw) ? pol : !pol;
        e.rgb = 12'h000;
        if (e.act) begin
            b     = e.x / (ha / 8);
            bb    = b[2:0];
            e.rgb = {{4{bb[2]}}, {4{bb[1]}}, {4{bb[0]}}};
        end
        return e;
    endfunction

    task automatic push_a(input int p0, input int p1);
        for (int p = p0; p <= p1; p++) qa.push_back(model(p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    endtask

    task automatic push_b(input int p0, input int p1);
        for (int p = p0; p <= p1; p++) qb.push_back(model(p, 640, 16, 96, 48, 4, 1, 1, 1, 1'b1));
    endtask

    task automatic cmp_upd(input string t, input exp_t e, input int x, input int y, input logic act,
                           input logic hs, input logic vs, input logic fs, input logic [11:0] rgb);
        bit bad;
        n_cmp++;
        bad = (x != e.x) || (y != e.y) || (act != e.act) || (hs != e.hs) ||
              (vs != e.vs) || (fs != e.fs);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        if (rgb != e.rgb) bad = 1'b1;
`endif
        if (bad) begin
            n_err++;
            $display("FAIL %s_update: got x=%0d y=%0d act=%0b hs=%0b vs=%0b fs=%0b rgb=%03h expected x=%0d y=%0d act=%0b hs=%0b vs=%0b fs=%0b rgb=%03h",
                     t, x, y, act, hs, vs, fs, rgb, e.x, e.y, e.act, e.hs, e.vs, e.fs, e.rgb);
        end
    endtask

    function automatic logic [11:0] rgb_of_a();
`ifdef VGA_TIMING_TEST_PATTERN_EN
        return {va.tp_red, va.tp_green, va.tp_blue};
`else
        return 12'h000;
`endif
    endfunction

    function automatic logic [11:0] rgb_of_b();
`ifdef VGA_TIMING_TEST_PATTERN_EN
        return {vb.tp_red, vb.tp_green, vb.tp_blue};
`else
        return 12'h000;
`endif
    endfunction

    task automatic chk_rst_a(input string t);
        chk({t, "_pxl_en"}, va.pxl_en, 0);
        chk({t, "_pxl_x"}, va.pxl_x, 0);
        chk({t, "_pxl_y"}, va.pxl_y, 0);
        chk({t, "_active"}, va.active, 0);
        chk({t, "_frame_start"}, va.frame_start, 0);
        chk({t, "_hsync"}, va.hsync, 1);
        chk({t, "_vsync"}, va.vsync, 1);
        chk({t, "_rgb"}, rgb_of_a(), 0);
    endtask

    task automatic chk_rst_b(input string t);
        chk({t, "_pxl_en"}, vb.pxl_en, 0);
        chk({t, "_pxl_x"}, vb.pxl_x, 0);
        chk({t, "_pxl_y"}, vb.pxl_y, 0);
        chk({t, "_active"}, vb.active, 0);
        chk({t, "_frame_start"}, vb.frame_start, 0);
        chk({t, "_hsync"}, vb.hsync, 0);
        chk({t, "_vsync"}, vb.vsync, 0);
        chk({t, "_rgb"}, rgb_of_b(), 0);
    endtask

    // Monitor A state: pxl_en spacing and line-0 hsync/active landmarks.
    bit     a_have_prev = 0;
    longint a_prev      = 0;
    int     a_hs_cnt = 0, a_hs_first = -1, a_hs_last = -1, a_act_fall = -1;
    bit     a_prev_act  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_a) begin
            a_have_prev = 0;
        end else if (va.pxl_en) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_pxl_en_x", va.pxl_x, -1);
            end else begin
                e = qa.pop_front();
                cmp_upd("a", e, int'(va.pxl_x), int'(va.pxl_y), va.active, va.hsync,
                        va.vsync, va.frame_start, rgb_of_a());
            end
            if (a_have_prev) chk("a_pxl_en_spacing", cyc - a_prev, 2);
            a_have_prev = 1;
            a_prev      = cyc;
            if (va.pxl_y == 0) begin
                if (va.hsync == 1'b0) begin
                    a_hs_cnt++;
                    if (a_hs_first < 0) a_hs_first = int'(va.pxl_x);
                    a_hs_last = int'(va.pxl_x);
                end
                if (a_prev_act && !va.active && a_act_fall < 0) a_act_fall = int'(va.pxl_x);
                a_prev_act = va.active;
            end
        end
    end

    // Monitor B state: spacing, frame period, vsync lines, test-pattern samples.
    bit     b_have_prev = 0, b_fs_seen = 0;
    longint b_prev = 0, b_fs_cyc = 0;
    int     b_en_cnt = 0, b_hs_cnt = 0, b_hs_first = -1, b_vs_min = 99, b_vs_max = -1;
    logic [11:0] b_rgb0 = 12'hABC, b_rgb560 = 12'hABC, b_rgb700 = 12'hABC;

    always @(negedge clk) begin
        exp_t e;
        if (rst_b) begin
            b_have_prev = 0;
            b_fs_seen   = 0;
        end else if (vb.pxl_en) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_pxl_en_x", vb.pxl_x, -1);
            end else begin
                e = qb.pop_front();
                cmp_upd("b", e, int'(vb.pxl_x), int'(vb.pxl_y), vb.active, vb.hsync,
                        vb.vsync, vb.frame_start, rgb_of_b());
            end
            if (b_have_prev) chk("b_pxl_en_spacing", cyc - b_prev, 1);
            b_have_prev = 1;
            b_prev      = cyc;
            b_en_cnt++;
            if (vb.frame_start) begin
                if (b_fs_seen) begin
                    chk("b_frame_period_clks", cyc - b_fs_cyc, 5600);
                    chk("b_pxl_en_per_frame", b_en_cnt, 5600);
                end
                b_fs_seen = 1;
                b_fs_cyc  = cyc;
                b_en_cnt  = 0;
            end
            if (!b_fs_seen && vb.pxl_y == 0 && vb.hsync) begin
                b_hs_cnt++;
                if (b_hs_first < 0) b_hs_first = int'(vb.pxl_x);
            end
            if (!b_fs_seen && vb.vsync) begin
                if (int'(vb.pxl_y) < b_vs_min) b_vs_min = int'(vb.pxl_y);
                if (int'(vb.pxl_y) > b_vs_max) b_vs_max = int'(vb.pxl_y);
            end
            if (vb.pxl_y == 0 && vb.pxl_x == 0)   b_rgb0   = rgb_of_b();
            if (vb.pxl_y == 0 && vb.pxl_x == 560) b_rgb560 = rgb_of_b();
            if (vb.pxl_y == 0 && vb.pxl_x == 700) b_rgb700 = rgb_of_b();
        end
    end

    initial begin
        // ---------------- DUT A: defaults ----------------
        repeat (5) begin
            @(negedge clk);
            chk_rst_a("a_in_reset");
        end
        rst_a = 1'b0;
        push_a(1, 1601);
        @(posedge clk); #1;
        chk("a_first_en_early", va.pxl_en, 0);
        @(posedge clk); #1;
        chk("a_first_en", va.pxl_en, 1);
        chk("a_first_x", va.pxl_x, 1);
        chk("a_first_y", va.pxl_y, 0);
        chk("a_first_active", va.active, 1);
        chk("a_first_frame_start", va.frame_start, 0);
        for (int i = 0; i < 5000 && qa.size() != 0; i++) @(posedge clk);
        chk("a_queue_drained", qa.size(), 0);
        qa.delete();
        #2 rst_a = 1'b1;
        chk("a_hsync_width", a_hs_cnt, 96);
        chk("a_hsync_first_x", a_hs_first, 656);
        chk("a_hsync_last_x", a_hs_last, 751);
        chk("a_active_fall_x", a_act_fall, 640);

        // ---------------- DUT B: CLK_DIV=1, SYNC_POL=1 ----------------
        repeat (5) begin
            @(negedge clk);
            chk_rst_b("b_in_reset");
        end
        rst_b = 1'b0;
        // Two full frames, then up to (299,3) of the third.
        push_b(1, 11200 + 2699);
        @(posedge clk); #1;
        chk("b_first_en", vb.pxl_en, 1);
        chk("b_first_x", vb.pxl_x, 1);
        chk("b_first_frame_start", vb.frame_start, 0);
        for (int i = 0; i < 20000 && qb.size() != 0; i++) @(posedge clk);
        chk("b_queue_drained", qb.size(), 0);
        qb.delete();
        #1;
        chk("b_mid_x", vb.pxl_x, 300);
        chk("b_mid_y", vb.pxl_y, 3);
        #1 rst_b = 1'b1;
        #1 chk_rst_b("b_async_reset");
        repeat (3) begin
            @(negedge clk);
            chk_rst_b("b_reset_hold");
        end
        rst_b = 1'b0;
        push_b(1, 10);
        @(posedge clk); #1;
        chk("b_restart_x", vb.pxl_x, 1);
        chk("b_restart_y", vb.pxl_y, 0);
        for (int i = 0; i < 100 && qb.size() != 0; i++) @(posedge clk);
        chk("b_restart_drained", qb.size(), 0);
        qb.delete();
        #2 rst_b = 1'b1;
        chk("b_hsync_width", b_hs_cnt, 96);
        chk("b_hsync_first_x", b_hs_first, 656);
        chk("b_vsync_first_line", b_vs_min, 5);
        chk("b_vsync_last_line", b_vs_max, 5);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        chk("b_tp_x0", b_rgb0, 12'h000);
        chk("b_tp_x560", b_rgb560, 12'hFFF);
        chk("b_tp_x700", b_rgb700, 12'h000);
`endif
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
